// File: rtl/up_down_mod_counter_pkg.sv
// Shared definitions for the up/down modulo counter slice.
//   DIR_UP / DIR_DOWN : encoding of the direction output and bounce state
//   WIDTH_MIN/MAX     : legal range of the WIDTH parameter
package up_down_mod_counter_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/up_down_mod_next.sv
// Combinational next-count logic for up_down_mod_counter.
// Ports:
//   data      current count
//   m         effective maximum (modulus - 1)
//   dir       current direction / bounce state
//   up        requested direction in linear mode
//   bounce    1 = ping-pong mode, 0 = linear mode
//   next_data count after one enabled step
//   next_dir  direction after one enabled step
//   tc        terminal-count flag for this step
module up_down_mod_next
  import up_down_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] m,
  input  dir_e             dir,
  input  logic             up,
  input  logic             bounce,
  output logic [WIDTH-1:0] next_data,
  output dir_e             next_dir,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    next_data = data;
    next_dir  = dir;
    tc        = 1'b0;

    if (!bounce) begin
      next_dir = up ? DIR_UP : DIR_DOWN;
    end

    if (m == '0) begin
      // Single-state modulus: every step is a terminal count, no turn.
      next_data = '0;
      tc        = 1'b1;
    end else if (!bounce) begin
      if (up) begin
        if (data < m) begin
          next_data = data + ONE;
        end else begin
          next_data = '0;
          tc        = 1'b1;
        end
      end else begin
        if (data == '0) begin
          next_data = m;
          tc        = 1'b1;
        end else if (data > m) begin
          next_data = m;
        end else begin
          next_data = data - ONE;
        end
      end
    end else if (dir == DIR_UP) begin
      if (data < m) begin
        next_data = data + ONE;
      end else begin
        next_data = m - ONE;
        next_dir  = DIR_DOWN;
        tc        = 1'b1;
      end
    end else begin
      if (data > m) begin
        next_data = m;
      end else if (data != '0) begin
        next_data = data - ONE;
      end else begin
        next_data = ONE;
        next_dir  = DIR_UP;
        tc        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/up_down_mod_counter.sv
// Up/down modulo-N counter with optional ping-pong (bounce) mode.
// Define UP_DOWN_MOD_COUNTER_BOUNCE_EN to enable bounce mode; otherwise the
// bounce port is present but ignored and only linear counting exists.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (data=0, tc=0, dir=1)
//   en        count enable
//   up        linear-mode direction (1 = up)
//   bounce    1 = ping-pong mode
//   N         modulus, 0 means 2^WIDTH
//   load      synchronous load strobe (beats en)
//   load_val  value to load, clamped to N-1
//   data      registered count
//   tc        registered terminal-count pulse
//   dir       registered current direction
module up_down_mod_counter
  import up_down_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             bounce,
  input  logic [WIDTH-1:0] N,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             dir
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] data_q, data_d, step_data, m;
  logic             tc_q, tc_d, step_tc, mode;
  dir_e             dir_q, dir_d, step_dir;

`ifdef UP_DOWN_MOD_COUNTER_BOUNCE_EN
  assign mode = bounce;
`else
  assign mode = bounce & 1'b0;
`endif

  // N=0 wraps to all-ones, which is exactly 2^WIDTH-1.
  assign m = N - ONE;

  up_down_mod_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .data     (data_q),
    .m        (m),
    .dir      (dir_q),
    .up       (up),
    .bounce   (mode),
    .next_data(step_data),
    .next_dir (step_dir),
    .tc       (step_tc)
  );

  always_comb begin
    data_d = data_q;
    tc_d   = 1'b0;
    dir_d  = dir_q;
    if (load) begin
      data_d = (load_val > m) ? m : load_val;
    end else if (en) begin
      data_d = step_data;
      tc_d   = step_tc;
      dir_d  = step_dir;
    end else if (!mode) begin
      // Linear mode tracks up even while idle so bounce starts from it.
      dir_d = up ? DIR_UP : DIR_DOWN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      tc_q   <= 1'b0;
      dir_q  <= DIR_UP;
    end else begin
      data_q <= data_d;
      tc_q   <= tc_d;
      dir_q  <= dir_d;
    end
  end

  assign data = data_q;
  assign tc   = tc_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_up_down_mod_counter.sv
module tb_up_down_mod_counter;

`ifdef UP_DOWN_MOD_COUNTER_BOUNCE_EN
  localparam bit BOUNCE_EN = 1'b1;
`else
  localparam bit BOUNCE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       bounce = 1'b0;
  logic [3:0] N = 4'd0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] data;
  logic       tc;
  logic       dir;

  int vectors = 0;
  int errors  = 0;

  // reference state
  int md, mtc, mdir;

  up_down_mod_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .bounce(bounce), .N(N),
    .load(load), .load_val(load_val), .data(data), .tc(tc), .dir(dir)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // One clock edge of the counter, stated directly from the behaviour rules.
  task automatic model_step;
    int mx, b;
    mx = (N == 0) ? 15 : int'(N) - 1;
    b  = BOUNCE_EN && bounce;
    if (load) begin
      md  = (int'(load_val) > mx) ? mx : int'(load_val);
      mtc = 0;
    end else if (en) begin
      mtc = 0;
      if (!b) mdir = up;
      if (mx == 0) begin
        md = 0; mtc = 1;
      end else if (!b) begin
        if (up) begin
          if (md < mx) md = md + 1; else begin md = 0; mtc = 1; end
        end else begin
          if (md == 0) begin md = mx; mtc = 1; end
          else if (md > mx) md = mx;
          else md = md - 1;
        end
      end else if (mdir == 1) begin
        if (md < mx) md = md + 1;
        else begin md = mx - 1; mdir = 0; mtc = 1; end
      end else begin
        if (md > mx) md = mx;
        else if (md > 0) md = md - 1;
        else begin md = 1; mdir = 1; mtc = 1; end
      end
    end else begin
      mtc = 0;
      if (!b) mdir = up;
    end
  endtask

  task automatic test_reset;
    en = 1'b0; load = 1'b0; bounce = 1'b0; up = 1'b1; N = 4'd0;
    do_reset();
    vectors++;
    if (data !== 4'd0 || tc !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got data=%0d tc=%0b dir=%0b, need data=0 tc=0 dir=1", data, tc, dir);
    end
  endtask

  task automatic test_linear_up;
    int ed[6] = '{1, 2, 3, 0, 1, 2};
    int et[6] = '{0, 0, 0, 1, 0, 0};
    do_reset();
    N = 4'd4; up = 1'b1; en = 1'b1; bounce = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (data !== 4'(ed[i]) || tc !== 1'(et[i])) begin
        errors++;
        $display("FAIL linear_up[%0d]: got data=%0d tc=%0b, need data=%0d tc=%0d", i, data, tc, ed[i], et[i]);
      end
    end
  endtask

  task automatic test_load_clamp;
    int ed[3] = '{1, 0, 2};
    int et[3] = '{0, 0, 1};
    N = 4'd3; up = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    vectors++;
    if (data !== 4'd2 || tc !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp: got data=%0d tc=%0b dir=%0b, need data=2 tc=0 dir=1", data, tc, dir);
    end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (data !== 4'(ed[i]) || tc !== 1'(et[i]) || dir !== 1'b0) begin
        errors++;
        $display("FAIL linear_down[%0d]: got data=%0d tc=%0b dir=%0b, need data=%0d tc=%0d dir=0",
                 i, data, tc, dir, ed[i], et[i]);
      end
    end
  endtask

  task automatic test_hold;
    en = 1'b0; load = 1'b0; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (data !== 4'd2 || tc !== 1'b0 || dir !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: got data=%0d tc=%0b dir=%0b, need data=2 tc=0 dir=1", i, data, tc, dir);
      end
    end
  endtask

  task automatic test_reset_midcount;
    N = 4'd8; en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; up = 1'b0;
    tick();
    vectors++;
    if (data !== 4'd4 || dir !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: got data=%0d dir=%0b, need data=4 dir=0", data, dir);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (data !== 4'd0 || tc !== 1'b0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got data=%0d tc=%0b dir=%0b, need data=0 tc=0 dir=1", data, tc, dir);
    end
    load = 1'b1; load_val = 4'd3;
    tick();
    vectors++;
    if (data !== 4'd0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: got data=%0d dir=%0b, need data=0 dir=1", data, dir);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0; up = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      vectors++;
      if (data !== 4'(i)) begin
        errors++;
        $display("FAIL post_reset[%0d]: got data=%0d, need data=%0d", i, data, i);
      end
    end
  endtask

  task automatic test_full_range;
    N = 4'd0; up = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd6;
    tick();
    vectors++;
    if (data !== 4'd6 || tc !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_en: got data=%0d tc=%0b, need data=6 tc=0", data, tc);
    end
    load = 1'b0;
    tick();
    vectors++;
    if (data !== 4'd7) begin
      errors++;
      $display("FAIL full_up: got data=%0d, need data=7", data);
    end
    load = 1'b1; load_val = 4'd15;
    tick();
    load = 1'b0;
    tick();
    vectors++;
    if (data !== 4'd0 || tc !== 1'b1) begin
      errors++;
      $display("FAIL full_wrap_up: got data=%0d tc=%0b, need data=0 tc=1", data, tc);
    end
    up = 1'b0;
    tick();
    vectors++;
    if (data !== 4'd15 || tc !== 1'b1) begin
      errors++;
      $display("FAIL full_wrap_down: got data=%0d tc=%0b, need data=15 tc=1", data, tc);
    end
  endtask

  task automatic test_mod1;
    do_reset();
    N = 4'd1; en = 1'b1; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      up = (i < 3);
      bounce = (i >= 4);
      tick();
      vectors++;
      if (data !== 4'd0 || tc !== 1'b1) begin
        errors++;
        $display("FAIL mod1[%0d]: got data=%0d tc=%0b, need data=0 tc=1", i, data, tc);
      end
    end
    bounce = 1'b0;
  endtask

  task automatic test_bounce;
    int ed[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int et[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
    int er[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    do_reset();
    N = 4'd4; up = 1'b1; en = 1'b1; load = 1'b0; bounce = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (BOUNCE_EN) begin
        if (data !== 4'(ed[i]) || tc !== 1'(et[i]) || dir !== 1'(er[i])) begin
          errors++;
          $display("FAIL bounce[%0d]: got data=%0d tc=%0b dir=%0b, need data=%0d tc=%0d dir=%0d",
                   i, data, tc, dir, ed[i], et[i], er[i]);
        end
      end else begin
        // bounce ignored: plain linear wrap 1,2,3,0,...
        if (data !== 4'((i + 1) % 4) || tc !== 1'(i % 4 == 3)) begin
          errors++;
          $display("FAIL bounce_ignored[%0d]: got data=%0d tc=%0b, need data=%0d tc=%0d",
                   i, data, tc, (i + 1) % 4, (i % 4 == 3));
        end
      end
    end
    bounce = 1'b0;
  endtask

  task automatic test_random;
    do_reset();
    md = 0; mtc = 0; mdir = 1;
    N = 4'd5;
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up       = ($urandom_range(0, 7) == 0) ? ~up : up;
      if ($urandom_range(0, 31) == 0) bounce = ~bounce;
      if ($urandom_range(0, 40) == 0) N = 4'($urandom_range(0, 15));
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      model_step();
      tick();
      vectors++;
      if (data !== 4'(md) || tc !== 1'(mtc) || dir !== 1'(mdir)) begin
        errors++;
        $display("FAIL random[%0d]: got data=%0d tc=%0b dir=%0b, need data=%0d tc=%0d dir=%0d",
                 i, data, tc, dir, md, mtc, mdir);
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_linear_up();
    test_load_clamp();
    test_hold();
    test_reset_midcount();
    test_full_range();
    test_mod1();
    test_bounce();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/up_down_mod_counter.md
UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of count, modulus and load value; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  count enable; no count step when low.
REQ-005 up  input  1  direction in linear mode: 1 = up, 0 = down.
REQ-006 bounce  input  1  1 selects ping-pong mode; 0 selects linear mode.
REQ-007 N  input  WIDTH  modulus; N=0 means 2^WIDTH.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value loaded when load=1.
REQ-010 data  output  WIDTH  registered count.
REQ-011 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-012 dir  output  1  registered current direction: 1 = up, 0 = down.

Function
REQ-013 Effective max M SHALL be N-1, or 2^WIDTH-1 when N=0; all arithmetic SHALL be WIDTH bits, unsigned.
REQ-014 data, tc and dir SHALL update only on the rising clk edge; the effect of any input SHALL be visible one cycle after it is sampled.
REQ-015 Priority SHALL be reset > load > en; with en=0 and load=0, data SHALL hold and tc SHALL be 0.
REQ-016 On load, data SHALL take load_val, or M if load_val > M; tc SHALL be 0; dir SHALL be unchanged.
REQ-017 Linear up (bounce=0, up=1): data < M -> data+1; data >= M -> 0, with tc=1.
REQ-018 Linear down (bounce=0, up=0): data = 0 -> M, with tc=1; data > M -> M, with tc=0; otherwise data-1.
REQ-019 In linear mode, dir SHALL follow up on every clock edge.
REQ-020 Bounce mode, state UP (dir=1): data < M -> data+1; data >= M -> M-1, dir<=0, tc=1.
REQ-021 Bounce mode, state DOWN (dir=0): data > M -> M; data > 0 -> data-1; data = 0 -> 1, dir<=1, tc=1.
REQ-022 M=0 (N=1): data SHALL stay 0 and tc SHALL be 1 on every enabled cycle, in either mode; dir SHALL be unchanged in bounce mode.
REQ-023 When bounce rises, the FSM SHALL start in the state held in dir, which is the last value of up.
REQ-024 Changing N mid-count SHALL take effect on the next enabled edge under REQ-017..REQ-021; no other correction is applied.

Reset
REQ-025 Asserting reset SHALL set data=0, tc=0, dir=1 immediately, without waiting for clk.
REQ-026 While reset is high, all inputs SHALL be ignored; the first step after release SHALL come from data=0.

Configuration
REQ-027 Macro UP_DOWN_MOD_COUNTER_BOUNCE_EN SHALL compile in ping-pong mode (REQ-020..REQ-023).
REQ-028 Without the macro, the bounce port SHALL remain but be ignored (treated as 0); only linear mode exists.

Structure
REQ-029 Shared package up_down_mod_counter_pkg SHALL hold DIR_UP=1, DIR_DOWN=0, WIDTH_MIN=2 and WIDTH_MAX=16.
REQ-030 Sub-module up_down_mod_next SHALL compute the combinational next-count, next-dir and tc from data, M, dir and mode; the top holds the registers and the load/enable priority.

Verification (WIDTH=4)
REQ-031 N=4, up=1, en=1, 6 clocks -> data 1,2,3,0,1,2; tc high only on the cycle data becomes 0.
REQ-032 N=3, up=0, load with load_val=9 -> data=2; then 3 clocks -> 1,0,2, with tc on the wrap to 2.
REQ-033 With the macro, N=4, bounce=1, from data=0 dir=1, 8 clocks -> 1,2,3,2,1,0,1,2; tc on the cycles data becomes 2 then 1 at the turns.
REQ-034 Counting at data=5 with N=8; reset pulsed high between clock edges -> data=0, dir=1, tc=0 at once; counting resumes 1,2 after release.
REQ-035 load=1 and en=1 in the same cycle, load_val=6, N=0 -> data=6 with no step; next enabled clock, up=1 -> 7; at data=15 the next step gives 0 with tc=1.
REQ-036 N=1, en=1 in both modes -> data stays 0 and tc stays 1 every cycle.
